// File: rtl/sync_fifo_wr_arb.sv
// ---------------------------------------------------------------------------
// sync_fifo_wr_arb
//   Round-robin write arbiter that lets NUM_REQ requesters share one
//   synchronous FIFO write port. A requester is granted for a burst of up to
//   MAX_BURST beats. One idle cycle always separates consecutive grants, and
//   the search for the next winner starts just past the last winner.
//
// Ports
//   i_clk            single clock
//   i_rst            synchronous active-high reset
//   i_req_valid      per-requester data valid
//   i_req_data       requester k data in bits [k*DATA_WIDTH +: DATA_WIDTH]
//   o_req_ready      per-requester accept (valid && ready = one beat)
//   i_fifo_full      FIFO full flag (stalls the burst, never ends it)
//   o_fifo_wr_en     FIFO write enable
//   o_fifo_wr_data   FIFO write data (combinational mux of granted requester)
//   o_grant          registered one-hot grant, zero when idle
//   o_grant_id       index of granted requester, zero when idle
//   o_busy           high while a grant is held
// ---------------------------------------------------------------------------
module sync_fifo_wr_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    output logic [NUM_REQ-1:0]            o_req_ready,
    input  logic                          i_fifo_full,
    output logic                          o_fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         o_fifo_wr_data,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic [$clog2(NUM_REQ)-1:0]    o_grant_id,
    output logic                          o_busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    gid_q, gid_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;

    logic               win_found;
    logic [ID_W-1:0]    win_id;
    logic [ID_W:0]      idx;
    logic               accept;
    logic               rel;

    // Unpack the flat data bus so the write mux is a plain array index.
    logic [DATA_WIDTH-1:0] req_words [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign req_words[k] = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
    end

    // First valid requester at or after ptr_q, wrapping. The extra idx bit
    // keeps ptr+i from overflowing before the modulo-NUM_REQ correction.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = {1'b0, ptr_q} + (ID_W+1)'(i);
            if (idx >= (ID_W+1)'(NUM_REQ))
                idx = idx - (ID_W+1)'(NUM_REQ);
            if (!win_found && i_req_valid[idx[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_id    = idx[ID_W-1:0];
            end
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d      = state_q;
        gid_d        = gid_q;
        grant_d      = grant_q;
        cnt_d        = cnt_q;
        ptr_d        = ptr_q;
        o_req_ready  = '0;
        o_fifo_wr_en = 1'b0;
        accept       = 1'b0;
        rel          = 1'b0;

        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d         = GRANT;
                    gid_d           = win_id;
                    grant_d         = '0;
                    grant_d[win_id] = 1'b1;
                    cnt_d           = '0;
                end
            end
            GRANT: begin
                o_req_ready[gid_q] = !i_fifo_full;
                accept             = i_req_valid[gid_q] && !i_fifo_full;
                o_fifo_wr_en       = accept;
                // Full with valid held stalls in place; only the requester
                // dropping valid or the last beat ends the burst.
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(MAX_BURST - 1))
                        rel = 1'b1;
                end else if (!i_req_valid[gid_q]) begin
                    rel = 1'b1;
                end
                if (rel) begin
                    state_d = IDLE;
                    gid_d   = '0;
                    grant_d = '0;
                    cnt_d   = '0;
                    ptr_d   = (gid_q == ID_W'(NUM_REQ - 1)) ? '0 : gid_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset blocks any handshake in the same cycle, not just the next.
        if (i_rst) begin
            o_req_ready  = '0;
            o_fifo_wr_en = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            gid_q   <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gid_q   <= gid_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign o_fifo_wr_data = req_words[gid_q];
    assign o_grant        = grant_q;
    assign o_grant_id     = gid_q;
    assign o_busy         = (state_q == GRANT);

endmodule

// File: tb/tb_sync_fifo_wr_arb.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_wr_arb
//   Bench for sync_fifo_wr_arb (NUM_REQ=4, DATA_WIDTH=64, MAX_BURST=8).
//   A behavioural arbiter model predicts grant/ready/write each cycle; each
//   requester emits a numbered word sequence so written data must arrive in
//   order. Directed scenarios pin the model's grant log to literal values,
//   followed by a long randomized run.
// ---------------------------------------------------------------------------
module tb_sync_fifo_wr_arb;

    localparam int N  = 4;
    localparam int W  = 64;
    localparam int MB = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   valid;
    logic [N*W-1:0] data;
    logic [N-1:0]   ready;
    logic           full;
    logic           wr_en;
    logic [W-1:0]   wr_data;
    logic [N-1:0]   grant;
    logic [1:0]     gid;
    logic           busy;

    always #5 clk = ~clk;

    sync_fifo_wr_arb #(.NUM_REQ(N), .DATA_WIDTH(W), .MAX_BURST(MB)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req_valid    (valid),
        .i_req_data     (data),
        .o_req_ready    (ready),
        .i_fifo_full    (full),
        .o_fifo_wr_en   (wr_en),
        .o_fifo_wr_data (wr_data),
        .o_grant        (grant),
        .o_grant_id     (gid),
        .o_busy         (busy)
    );

    int errors = 0;
    int checks = 0;
    int seq [N];

    // Model state: who holds the grant, beats taken, where the search starts.
    bit m_busy;
    int m_g, m_cnt, m_ptr;
    int glog [$];
    int wlog [$];
    int busy_cnt;

    function automatic logic [W-1:0] word(int k, int s);
        return {16'hA5A5, 8'(k), 8'h00, 32'(s)};
    endfunction

    task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Called at posedge+1 with valid/full/rst already set; returns at the
    // next posedge+1.
    task automatic cycle();
        logic [N-1:0] e_grant, e_ready;
        logic         e_wr;
        bit           found;
        for (int k = 0; k < N; k++) data[k*W +: W] = word(k, seq[k]);
        #3;
        e_grant = '0;
        if (m_busy) e_grant[m_g] = 1'b1;
        e_ready = '0;
        if (!rst && m_busy && !full) e_ready[m_g] = 1'b1;
        e_wr = !rst && m_busy && valid[m_g] && !full;

        chk("grant",    grant, e_grant);
        chk("grant_id", gid,   m_busy ? m_g : 0);
        chk("busy",     busy,  m_busy);
        chk("ready",    ready, e_ready);
        chk("wr_en",    wr_en, e_wr);
        chk("onehot0",  $onehot0(grant), 1);
        if (busy) busy_cnt++;
        if (e_wr) begin
            chk("wr_data", wr_data, word(m_g, seq[m_g]));
            seq[m_g]++;
            if (wlog.size() > 0) wlog[wlog.size()-1]++;
        end

        if (rst) begin
            m_busy = 0; m_g = 0; m_cnt = 0; m_ptr = 0;
        end else if (!m_busy) begin
            found = 0;
            for (int i = 0; i < N; i++) begin
                if (!found && valid[(m_ptr + i) % N]) begin
                    found  = 1;
                    m_g    = (m_ptr + i) % N;
                    m_busy = 1;
                    m_cnt  = 0;
                    glog.push_back(m_g);
                    wlog.push_back(0);
                end
            end
        end else if (e_wr || !valid[m_g]) begin
            if (e_wr) m_cnt++;
            if (!e_wr || m_cnt == MB) begin
                m_ptr  = (m_g + 1) % N;
                m_busy = 0; m_g = 0; m_cnt = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; valid = '0; full = 1'b0;
        cycle();
        rst = 1'b0;
        glog.delete();
        wlog.delete();
        busy_cnt = 0;
    endtask

    task automatic check_log(string nm, int eg [$], int ew [$]);
        chk({nm, "_ngrants"}, glog.size(), eg.size());
        for (int i = 0; i < eg.size(); i++) begin
            if (i < glog.size()) begin
                chk({nm, "_gid"},    glog[i], eg[i]);
                chk({nm, "_writes"}, wlog[i], ew[i]);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int eg [$];
        int ew [$];
        int guard, full_left;
        bit full_done;

        foreach (seq[k]) seq[k] = 0;
        m_busy = 0; m_g = 0; m_cnt = 0; m_ptr = 0; busy_cnt = 0;
        rst = 1'b1; valid = '0; full = 1'b0; data = '0;
        @(posedge clk); #1;
        do_reset();

        // Reset state and a quiet idle cycle.
        #3;
        chk("rst_grant", grant, 4'b0000);
        chk("rst_busy",  busy,  1'b0);
        chk("rst_gid",   gid,   2'd0);
        chk("rst_wr_en", wr_en, 1'b0);
        @(posedge clk); #1;

        // Single requester, 20 beats: bursts of 8, 8, 4.
        do_reset();
        guard = 0;
        begin
            int base;
            base = seq[2];
            while (seq[2] - base < 20 && guard < 100) begin
                valid = 4'b0100; cycle(); guard++;
            end
        end
        valid = '0; cycle();
        eg = '{2, 2, 2}; ew = '{8, 8, 4};
        check_log("single", eg, ew);

        // All valid: rotation 0,1,2,3,0 with full bursts.
        do_reset();
        repeat (45) begin valid = '1; cycle(); end
        valid = '0; repeat (2) cycle();
        eg = '{0, 1, 2, 3, 0}; ew = '{8, 8, 8, 8, 8};
        check_log("rotate", eg, ew);

        // Backpressure: full for 5 cycles after beat 3 of req 1.
        do_reset();
        full_left = 0; full_done = 0;
        repeat (14) begin
            valid = 4'b0010;
            if (m_busy && m_cnt == 3 && !full_done) begin
                full_left = 5; full_done = 1;
            end
            full = (full_left > 0);
            if (full_left > 0) full_left--;
            cycle();
        end
        full = 1'b0; valid = '0; cycle();
        eg = '{1}; ew = '{8};
        check_log("bp", eg, ew);
        chk("bp_busy_cycles", busy_cnt, 13);

        // Early release: req 0 drops valid after beat 3, then 0 and 3 compete.
        do_reset();
        guard = 0;
        while (!(m_busy && m_cnt == 3) && guard < 50) begin
            valid = 4'b0001; cycle(); guard++;
        end
        valid = '0; cycle();
        chk("early_ptr", m_ptr, 1);
        valid = 4'b1001; cycle();
        valid = '0; cycle();
        eg = '{0, 3}; ew = '{3, 0};
        check_log("early", eg, ew);

        // Reset during beat 5 of req 3, then 0 and 3 compete from rr_ptr 0.
        do_reset();
        guard = 0;
        while (!(m_busy && m_cnt == 4) && guard < 50) begin
            valid = 4'b1000; cycle(); guard++;
        end
        rst = 1'b1; valid = 4'b1000; cycle();
        rst = 1'b0;
        valid = 4'b1001; cycle();
        valid = '0; cycle();
        eg = '{3, 0}; ew = '{4, 0};
        check_log("midrst", eg, ew);

        // Randomized traffic with backpressure and occasional reset.
        do_reset();
        repeat (3000) begin
            for (int k = 0; k < N; k++)
                if ($urandom_range(0, 3) == 0) valid[k] = ($urandom_range(0, 99) < 70);
            full = ($urandom_range(0, 99) < 20);
            rst  = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst = 1'b0; valid = '0; full = 1'b0;
        repeat (3) cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
